mem_bank: RTL and testbench
===========================

MEM_BANK -- requirements
Module: mem_bank

Parameters
REQ-001 ADDR_W, default 18: word-address width; the array holds 2**ADDR_W 36-bit words.
REQ-002 ACK_DLY, default 0, range 0..15: idle cycles between START acceptance and the first transfer slot.
REQ-003 RMW_EN, default 1: when 1, per-word write is supported; when 0, WR requests are handled as reads.

Interface
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 CROBAR_N  in  1  reset, synchronous and active-low.
REQ-006 START  in  1  request strobe, sampled only in IDLE.
REQ-007 RQ  in  4  [0:3] word-request mask, RQ[0] first slot.
REQ-008 WR  in  1  1 = write cycle, 0 = read cycle; sampled with START.
REQ-009 ADR  in  22  [14:35] word address; [34:35] is the starting word offset.
REQ-010 DIN  in  36  write data, sampled in slots where ACKN=1 and the cycle is a write.
REQ-011 DIN_PAR  in  1  even parity of DIN.
REQ-012 D  out  36  read data; zero when VALID=0.
REQ-013 PARITY  out  1  XOR of D; zero when VALID=0.
REQ-014 ACKN  out  1  word-acknowledge for the current slot.
REQ-015 VALID  out  1  read-data valid for the current slot.
REQ-016 NXM  out  1  one-cycle pulse when the address is nonexistent.
REQ-017 PAR_ERR  out  1  sticky flag for a write parity error.
REQ-018 BUSY  out  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, DLY, XFER; the reset state is IDLE.
REQ-020 IDLE, START=1, RQ!=0, ADR[14:35-ADDR_W]==0:
  - latch base = ADR, wo = ADR[34:35], mask = RQ, wr = WR & RMW_EN;
  - go to DLY if ACK_DLY>0, else go to XFER.
REQ-021 IDLE, START=1, ADR[14:35-ADDR_W]!=0: NXM=1 for one cycle; no state change; no array access.
REQ-022 IDLE, START=1, RQ==0: ignore the request, stay in IDLE, no NXM.
REQ-023 DLY: a counter loaded with ACK_DLY-1 decrements each cycle; at 0, go to XFER.
REQ-024 XFER, one slot per cycle:
  - ACKN = mask[0];
  - then mask <= mask<<1 and wo <= wo+1 mod 4 (the word offset wraps inside the quadword; base[14:33] is unchanged).
REQ-025 Zero mask bits are consumed as empty slots: ACKN=0 and VALID=0, and wo still advances.
REQ-026 Read slot with mask[0]=1:
  - VALID=1;
  - D = array[{base[36-ADDR_W:33], wo}] combinationally in the same cycle;
  - PARITY = ^D.
REQ-027 Write slot with mask[0]=1:
  - VALID=0;
  - on the clock edge, array[{base[36-ADDR_W:33], wo}] <= DIN;
  - if ^DIN != DIN_PAR, PAR_ERR <= 1 and the write still occurs.
REQ-028 XFER with the next mask == 0: go to IDLE; trailing zero bits are not clocked out.
REQ-029 START is ignored while BUSY=1. A START held through the IDLE cycle that follows completion is accepted in that IDLE cycle, which is the minimum gap of one cycle.
REQ-030 The array is not initialised by reset; its contents survive reset.

Reset
REQ-031 While CROBAR_N=0 at a posedge:
  - state goes to IDLE;
  - mask, wo, counter and PAR_ERR are cleared;
  - ACKN, VALID, NXM, BUSY, D and PARITY are 0 in the following cycle.
REQ-032 Reset during DLY or XFER aborts the cycle; no array write occurs in the reset cycle.

Verification
REQ-033 ACK_DLY=0: preload array[0o100..0o103]; read ADR=0o101, RQ=1111 -> ACKN/VALID high 4 cycles; D = words 0o101, 0o102, 0o103, 0o100 in that order.
REQ-034 Read RQ=1010, ADR=0o200 -> slot 1 returns word 0o200, slot 2 empty, slot 3 returns word 0o202, then IDLE; BUSY high 3 cycles.
REQ-035 ACK_DLY=3: write RQ=0001, ADR=0o7, DIN=0o123456654321 with good parity -> first ACKN 7 cycles after START (3 DLY + 3 empty slots); readback returns the value with PARITY=^value.
REQ-036 ADDR_W=18, ADR=0o1000000 -> NXM pulses 1 cycle, BUSY stays 0, no ACKN.
REQ-037 Write with a bad DIN_PAR -> PAR_ERR=1 and stays 1 until CROBAR_N=0; the word is stored.
REQ-038 Assert CROBAR_N=0 in the second slot of a 4-word write -> word 2 is unchanged, all outputs are 0 the next cycle, and a new START is accepted after release.

Source files
------------

// File: rtl/mem_bank.sv
// Quadword-oriented 36-bit memory bank: a START request moves up to four words,
// one slot per cycle, wrapping the word offset inside the addressed quadword.
module mem_bank #(
    parameter int ADDR_W  = 18,
    parameter int ACK_DLY = 0,
    parameter bit RMW_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          CROBAR_N,
    input  logic          START,
    input  logic [0:3]    RQ,
    input  logic          WR,
    input  logic [14:35]  ADR,
    input  logic [35:0]   DIN,
    input  logic          DIN_PAR,
    output logic [35:0]   D,
    output logic          PARITY,
    output logic          ACKN,
    output logic          VALID,
    output logic          NXM,
    output logic          PAR_ERR,
    output logic          BUSY
);

    localparam int DATA_W = 36;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, DLY, XFER} state_t;

    state_t              state;
    logic [ADDR_W-3:0]   base_hi;
    logic [1:0]          wo;
    logic [0:3]          mask;
    logic [0:3]          mask_nxt;
    logic                wr;
    logic [CNT_W-1:0]    cnt;
    logic                nxm_q;
    logic                par_err_q;
    logic [21:0]         adr_num;
    logic                adr_bad;
    logic                slot;
    logic [ADDR_W-1:0]   idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic par36(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    // ADR bit 35 is the least significant, so the packed copy is numeric
    assign adr_num  = ADR;
    assign adr_bad  = (adr_num >> ADDR_W) != 22'd0;
    assign mask_nxt = mask << 1;
    assign idx      = {base_hi, wo};
    assign slot     = (state == XFER) && mask[0];

    always_ff @(posedge clk) begin
        if (!CROBAR_N) begin
            state     <= IDLE;
            mask      <= '0;
            wo        <= '0;
            cnt       <= '0;
            wr        <= 1'b0;
            nxm_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            nxm_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && RQ != 4'b0000) begin
                        if (adr_bad) begin
                            nxm_q <= 1'b1;
                        end else begin
                            base_hi <= adr_num[ADDR_W-1:2];
                            wo      <= adr_num[1:0];
                            mask    <= RQ;
                            wr      <= WR & RMW_EN;
                            cnt     <= (ACK_DLY > 0) ? CNT_W'(ACK_DLY - 1) : '0;
                            state   <= (ACK_DLY > 0) ? DLY : XFER;
                        end
                    end
                end
                DLY: begin
                    if (cnt == '0) state <= XFER;
                    else           cnt   <= cnt - 1'b1;
                end
                XFER: begin
                    // empty slots still advance the offset; trailing empties end the cycle
                    mask <= mask_nxt;
                    wo   <= wo + 2'd1;
                    if (slot && wr && (par36(DIN) != DIN_PAR)) par_err_q <= 1'b1;
                    if (mask_nxt == 4'b0000) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset blocks the write so an aborted cycle leaves the array untouched
    always_ff @(posedge clk) begin
        if (CROBAR_N && slot && wr) mem[idx] <= DIN;
    end

    assign BUSY    = (state != IDLE);
    assign ACKN    = slot;
    assign VALID   = slot && !wr;
    assign D       = VALID ? mem[idx] : '0;
    assign PARITY  = par36(D);
    assign NXM     = nxm_q;
    assign PAR_ERR = par_err_q;

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank: one instance with no acknowledge delay, one with ACK_DLY=3.
module tb_mem_bank;

    logic        clk = 1'b0;
    logic        crobar_n, start_a, start_b, wr, din_par;
    logic [0:3]  rq;
    logic [21:0] adr;
    logic [35:0] din;

    logic [35:0] d_a, d_b;
    logic        par_a, ackn_a, valid_a, nxm_a, perr_a, busy_a;
    logic        par_b, ackn_b, valid_b, nxm_b, perr_b, busy_b;

    int tests = 0;
    int fails = 0;

    logic [35:0] w   [4] = '{36'o123400000100, 36'o765400000101, 36'o000077770102, 36'o252525250103};
    logic [35:0] old [4] = '{36'o111100000400, 36'o222200000401, 36'o333300000402, 36'o444400000403};
    logic [35:0] nw  [4] = '{36'o555500000400, 36'o666600000401, 36'o777700000402, 36'o000100000403};

    always #5 clk = ~clk;

    mem_bank #(.ADDR_W(18), .ACK_DLY(0), .RMW_EN(1'b1)) dut_a (
        .clk(clk), .CROBAR_N(crobar_n), .START(start_a), .RQ(rq), .WR(wr), .ADR(adr),
        .DIN(din), .DIN_PAR(din_par), .D(d_a), .PARITY(par_a), .ACKN(ackn_a),
        .VALID(valid_a), .NXM(nxm_a), .PAR_ERR(perr_a), .BUSY(busy_a));

    mem_bank #(.ADDR_W(18), .ACK_DLY(3), .RMW_EN(1'b1)) dut_b (
        .clk(clk), .CROBAR_N(crobar_n), .START(start_b), .RQ(rq), .WR(wr), .ADR(adr),
        .DIN(din), .DIN_PAR(din_par), .D(d_b), .PARITY(par_b), .ACKN(ackn_b),
        .VALID(valid_b), .NXM(nxm_b), .PAR_ERR(perr_b), .BUSY(busy_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in the first cycle after acceptance
    task automatic begin_req(input logic on_b, input logic [0:3] q, input logic w_en, input logic [21:0] a);
        rq = q; wr = w_en; adr = a;
        if (on_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic test_reset();
        crobar_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        rq = 4'b0000; wr = 1'b0; adr = '0; din = '0; din_par = 1'b0;
        tick(); tick();
        tests++; if (busy_a !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        tests++; if (ackn_a !== 1'b0)  begin fails++; $display("FAIL reset_ackn: got %b want 0", ackn_a); end
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        tests++; if (nxm_a !== 1'b0)   begin fails++; $display("FAIL reset_nxm: got %b want 0", nxm_a); end
        tests++; if (perr_a !== 1'b0)  begin fails++; $display("FAIL reset_par_err: got %b want 0", perr_a); end
        tests++; if (d_a !== 36'o0)    begin fails++; $display("FAIL reset_d: got %o want 0", d_a); end
        tests++; if (par_a !== 1'b0)   begin fails++; $display("FAIL reset_parity: got %b want 0", par_a); end
        tests++; if (busy_b !== 1'b0)  begin fails++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        crobar_n = 1'b1;
        tick();
    endtask

    task automatic test_preload();
        begin_req(1'b0, 4'b1111, 1'b1, 22'o100);
        for (int i = 0; i < 4; i++) begin
            din = w[i]; din_par = ^w[i];
            tests++; if (ackn_a !== 1'b1 || valid_a !== 1'b0)
                begin fails++; $display("FAIL preload_ack[%0d]: got ackn=%b valid=%b want 1/0", i, ackn_a, valid_a); end
            tick();
        end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL preload_done: busy=%b want 0", busy_a); end
        tests++; if (perr_a !== 1'b0) begin fails++; $display("FAIL preload_par_err: got %b want 0", perr_a); end
    endtask

    task automatic test_read_wrap();
        logic [35:0] exp;
        begin_req(1'b0, 4'b1111, 1'b0, 22'o101);
        for (int i = 0; i < 4; i++) begin
            exp = w[(i + 1) % 4];
            tests++; if (ackn_a !== 1'b1 || valid_a !== 1'b1)
                begin fails++; $display("FAIL wrap_ack[%0d]: got ackn=%b valid=%b want 1/1", i, ackn_a, valid_a); end
            tests++; if (d_a !== exp) begin fails++; $display("FAIL wrap_d[%0d]: got %o want %o", i, d_a, exp); end
            tests++; if (par_a !== ^exp) begin fails++; $display("FAIL wrap_parity[%0d]: got %b want %b", i, par_a, ^exp); end
            tick();
        end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL wrap_done: busy=%b want 0", busy_a); end
    endtask

    task automatic test_sparse();
        logic [35:0] x200, x202;
        int busy_cnt;
        x200 = 36'o444400000200; x202 = 36'o101000000202;
        begin_req(1'b0, 4'b1010, 1'b1, 22'o200);
        din = x200; din_par = ^x200; tick();
        din = '0; din_par = 1'b0; tick();
        din = x202; din_par = ^x202; tick();
        begin_req(1'b0, 4'b1010, 1'b0, 22'o200);
        busy_cnt = 0;
        if (busy_a === 1'b1) busy_cnt++;
        tests++; if (valid_a !== 1'b1 || d_a !== x200) begin fails++; $display("FAIL sparse_slot1: valid=%b d=%o want 1 %o", valid_a, d_a, x200); end
        tick();
        if (busy_a === 1'b1) busy_cnt++;
        tests++; if (ackn_a !== 1'b0 || valid_a !== 1'b0 || d_a !== 36'o0)
            begin fails++; $display("FAIL sparse_slot2: ackn=%b valid=%b d=%o want 0 0 0", ackn_a, valid_a, d_a); end
        tick();
        if (busy_a === 1'b1) busy_cnt++;
        tests++; if (valid_a !== 1'b1 || d_a !== x202) begin fails++; $display("FAIL sparse_slot3: valid=%b d=%o want 1 %o", valid_a, d_a, x202); end
        tick();
        if (busy_a === 1'b1) busy_cnt++;
        tests++; if (busy_cnt != 3) begin fails++; $display("FAIL sparse_busy_cycles: got %0d want 3", busy_cnt); end
    endtask

    task automatic test_nxm();
        begin_req(1'b0, 4'b1111, 1'b0, 22'o1000000);
        tests++; if (nxm_a !== 1'b1) begin fails++; $display("FAIL nxm_pulse: got %b want 1", nxm_a); end
        tests++; if (busy_a !== 1'b0 || ackn_a !== 1'b0) begin fails++; $display("FAIL nxm_idle: busy=%b ackn=%b want 0 0", busy_a, ackn_a); end
        tick();
        tests++; if (nxm_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL nxm_one_cycle: nxm=%b busy=%b want 0 0", nxm_a, busy_a); end
    endtask

    task automatic test_rq_zero();
        begin_req(1'b0, 4'b0000, 1'b0, 22'o100);
        tests++; if (busy_a !== 1'b0 || nxm_a !== 1'b0) begin fails++; $display("FAIL rq_zero: busy=%b nxm=%b want 0 0", busy_a, nxm_a); end
    endtask

    task automatic test_back_to_back();
        rq = 4'b1000; wr = 1'b0; adr = 22'o100; start_a = 1'b1;
        tick();
        tests++; if (ackn_a !== 1'b1 || d_a !== w[0]) begin fails++; $display("FAIL b2b_first: ackn=%b d=%o want 1 %o", ackn_a, d_a, w[0]); end
        tick();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL b2b_gap: busy=%b want 0", busy_a); end
        tick();
        start_a = 1'b0;
        tests++; if (ackn_a !== 1'b1 || d_a !== w[0]) begin fails++; $display("FAIL b2b_second: ackn=%b d=%o want 1 %o", ackn_a, d_a, w[0]); end
        tick();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL b2b_done: busy=%b want 0", busy_a); end
    endtask

    task automatic test_par_err();
        logic [35:0] x300;
        x300 = 36'o707070707070;
        begin_req(1'b0, 4'b1000, 1'b1, 22'o300);
        din = x300; din_par = ~(^x300);
        tick();
        din_par = 1'b0;
        tests++; if (perr_a !== 1'b1) begin fails++; $display("FAIL par_err_set: got %b want 1", perr_a); end
        tick(); tick();
        tests++; if (perr_a !== 1'b1) begin fails++; $display("FAIL par_err_sticky: got %b want 1", perr_a); end
        begin_req(1'b0, 4'b1000, 1'b0, 22'o300);
        tests++; if (d_a !== x300) begin fails++; $display("FAIL par_err_stored: got %o want %o", d_a, x300); end
        tick();
        tests++; if (perr_a !== 1'b1) begin fails++; $display("FAIL par_err_after_read: got %b want 1", perr_a); end
    endtask

    task automatic test_ack_dly();
        logic [35:0] val;
        int lat;
        val = 36'o123456654321;
        din = val; din_par = ^val;
        begin_req(1'b1, 4'b0001, 1'b1, 22'o7);
        lat = 1;
        while (ackn_b !== 1'b1 && lat < 20) begin tick(); lat++; end
        tests++; if (lat != 7) begin fails++; $display("FAIL dly_write_latency: got %0d want 7", lat); end
        tick();
        tests++; if (busy_b !== 1'b0 || perr_b !== 1'b0) begin fails++; $display("FAIL dly_write_done: busy=%b par_err=%b want 0 0", busy_b, perr_b); end
        din = '0; din_par = 1'b0;
        begin_req(1'b1, 4'b0001, 1'b0, 22'o7);
        lat = 1;
        while (ackn_b !== 1'b1 && lat < 20) begin tick(); lat++; end
        tests++; if (lat != 7) begin fails++; $display("FAIL dly_read_latency: got %0d want 7", lat); end
        tests++; if (valid_b !== 1'b1 || d_b !== val) begin fails++; $display("FAIL dly_readback: valid=%b d=%o want 1 %o", valid_b, d_b, val); end
        tests++; if (par_b !== ^val) begin fails++; $display("FAIL dly_parity: got %b want %b", par_b, ^val); end
        tick();
        // offset wrapped 3 -> 2, so the word landed at 0o6
        begin_req(1'b1, 4'b1000, 1'b0, 22'o6);
        lat = 1;
        while (ackn_b !== 1'b1 && lat < 20) begin tick(); lat++; end
        tests++; if (lat != 4) begin fails++; $display("FAIL dly_word6_latency: got %0d want 4", lat); end
        tests++; if (d_b !== val) begin fails++; $display("FAIL dly_word6: got %o want %o", d_b, val); end
        tick();
    endtask

    task automatic test_reset_mid();
        begin_req(1'b0, 4'b1111, 1'b1, 22'o400);
        for (int i = 0; i < 4; i++) begin din = old[i]; din_par = ^old[i]; tick(); end
        begin_req(1'b0, 4'b1111, 1'b1, 22'o400);
        din = nw[0]; din_par = ^nw[0];
        tick();
        din = nw[1]; din_par = ^nw[1];
        tests++; if (ackn_a !== 1'b1) begin fails++; $display("FAIL abort_slot2_ack: got %b want 1", ackn_a); end
        crobar_n = 1'b0;
        tick();
        tests++; if (busy_a !== 1'b0 || ackn_a !== 1'b0 || valid_a !== 1'b0 || nxm_a !== 1'b0)
            begin fails++; $display("FAIL abort_ctrl: busy=%b ackn=%b valid=%b nxm=%b want 0000", busy_a, ackn_a, valid_a, nxm_a); end
        tests++; if (d_a !== 36'o0 || par_a !== 1'b0 || perr_a !== 1'b0)
            begin fails++; $display("FAIL abort_data: d=%o parity=%b par_err=%b want 0 0 0", d_a, par_a, perr_a); end
        crobar_n = 1'b1;
        tick();
        begin_req(1'b0, 4'b1100, 1'b0, 22'o400);
        tests++; if (ackn_a !== 1'b1 || d_a !== nw[0]) begin fails++; $display("FAIL abort_word1: ackn=%b d=%o want 1 %o", ackn_a, d_a, nw[0]); end
        tick();
        tests++; if (d_a !== old[1]) begin fails++; $display("FAIL abort_word2_kept: got %o want %o", d_a, old[1]); end
        tick();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL abort_read_done: busy=%b want 0", busy_a); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_wrap();
        test_sparse();
        test_nxm();
        test_rq_zero();
        test_back_to_back();
        test_par_err();
        test_ack_dly();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
